// File: rtl/sdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_pkg
//  Description : Shared types and defaults for the SD card write sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdc_pkg;

    // Sequencer FSM encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFETCH  = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_CARD_BUSY = 3'd4,
        ST_FINISH    = 3'd5
    } sdc_state_t;

    localparam int c_BLOCK_BYTES_DEF  = 512;
    localparam int c_BUSY_TIMEOUT_DEF = 1 << 20;

endpackage
`default_nettype wire

// File: rtl/sdc_prefetch_q.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_prefetch_q
//  Description : Two-entry byte queue between the sector buffer read port and
//                the transmitter byte stream. Push and pop in the same cycle
//                leave the occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdc_prefetch_q (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic [1:0] o_count
);

    logic [7:0] r_mem [2];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    // A pop on an empty queue and a push into a full one (without pop) are ignored
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= 8'h00;
            r_mem[1] <= 8'h00;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sdc_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_write_sequencer
//  Description : Multi-block write sequencer for the SD data-line transmitter.
//                Streams sector-buffer bytes gap-free, tags block ends, tracks
//                card busy between blocks and reports done/abort/timeout.
//                Optional macro SDC_WRSEQ_STATS_EN adds the busyCycles counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdc_write_sequencer
    import sdc_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int BLOCK_BYTES  = c_BLOCK_BYTES_DEF,
    parameter int BUSY_TIMEOUT = c_BUSY_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [15:0]       blockCount,
    input  logic              abort,
    output logic [ADDR_W-1:0] bufAddr,
    output logic              bufRd,
    input  logic [7:0]        bufData,
    output logic [7:0]        txData,
    output logic              txValid,
    output logic              txLast,
    input  logic              txReady,
    input  logic              txWaiting,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              timeout,
    output logic [15:0]       blocksDone
`ifdef SDC_WRSEQ_STATS_EN
    ,
    output logic [31:0]       busyCycles
`endif
);

    localparam int c_CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam int c_TMO_W = $clog2(BUSY_TIMEOUT + 1);

    sdc_state_t          r_state;
    sdc_state_t          w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_count;
    logic [15:0]         r_blocksDone;
    logic                r_aborted;
    logic                r_timeout;
    logic [c_CNT_W-1:0]  r_rdCnt;
    logic [c_CNT_W-1:0]  r_popCnt;
    logic [1:0]          r_pfCnt;
    logic                r_rdPend;
    logic [c_TMO_W-1:0]  r_tmo;

    logic                w_stream;
    logic                w_pop;
    logic                w_rd;
    logic                w_lastByte;
    logic                w_busyPhase;
    logic                w_tmoHit;
    logic                w_release;
    logic [15:0]         w_nextBlocks;
    logic                w_finalBlk;
    logic [7:0]          w_qHead;
    logic [1:0]          w_qCount;

    assign w_stream     = (r_state == ST_STREAM);
    assign w_pop        = w_stream && txReady;
    assign w_lastByte   = (r_popCnt == c_CNT_W'(BLOCK_BYTES - 1));
    assign w_busyPhase  = (r_state == ST_WAIT_BUSY) || (r_state == ST_CARD_BUSY);
    assign w_tmoHit     = w_busyPhase && (r_tmo == c_TMO_W'(BUSY_TIMEOUT - 1));
    assign w_release    = (r_state == ST_CARD_BUSY) && !txWaiting && !w_tmoHit;
    assign w_nextBlocks = r_blocksDone + 16'd1;
    assign w_finalBlk   = (w_nextBlocks == r_count);

    // Buffer reads: two to fill the queue, then one per popped byte until the block is fully fetched
    always_comb begin
        w_rd = 1'b0;
        if (r_state == ST_PREFETCH) begin
            w_rd = (r_pfCnt != 2'd2);
        end else if (w_stream) begin
            w_rd = w_pop && (r_rdCnt != c_CNT_W'(BLOCK_BYTES));
        end
    end

    sdc_prefetch_q u_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rdPend),
        .i_data  (bufData),
        .i_pop   (w_pop),
        .o_head  (w_qHead),
        .o_count (w_qCount)
    );

    // Next-state logic; timeout takes priority over busy handshake progress
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (blockCount == 16'd0) ? ST_FINISH : ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                if (r_rdPend && (w_qCount == 2'd1)) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_pop && w_lastByte) begin
                    w_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (w_tmoHit) begin
                    w_next = ST_FINISH;
                end else if (txWaiting) begin
                    w_next = ST_CARD_BUSY;
                end
            end
            ST_CARD_BUSY: begin
                if (w_tmoHit) begin
                    w_next = ST_FINISH;
                end else if (!txWaiting) begin
                    w_next = (w_finalBlk || abort) ? ST_FINISH : ST_PREFETCH;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register and read-pipeline tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rdPend <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rdPend <= w_rd;
        end
    end

    // Address, per-block byte counters and busy-phase timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_count  <= 16'd0;
            r_rdCnt  <= '0;
            r_popCnt <= '0;
            r_pfCnt  <= 2'd0;
            r_tmo    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_addr  <= startAddr;
                r_count <= blockCount;
            end else if (w_rd) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_pop && w_lastByte) begin
                r_rdCnt  <= '0;
                r_popCnt <= '0;
            end else begin
                if (w_rd) begin
                    r_rdCnt <= r_rdCnt + 1'b1;
                end
                if (w_pop) begin
                    r_popCnt <= r_popCnt + 1'b1;
                end
            end

            if (((r_state == ST_IDLE) && start) || w_release) begin
                r_pfCnt <= 2'd0;
            end else if ((r_state == ST_PREFETCH) && w_rd) begin
                r_pfCnt <= r_pfCnt + 2'd1;
            end

            if (w_pop && w_lastByte) begin
                r_tmo <= '0;
            end else if (w_busyPhase) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Operation status: cleared on start, updated at block boundaries and on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blocksDone <= 16'd0;
            r_aborted    <= 1'b0;
            r_timeout    <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_blocksDone <= 16'd0;
            r_aborted    <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_tmoHit) begin
            r_timeout <= 1'b1;
        end else if (w_release) begin
            r_blocksDone <= w_nextBlocks;
            r_aborted    <= abort && !w_finalBlk;
        end
    end

`ifdef SDC_WRSEQ_STATS_EN
    logic [31:0] r_busyCycles;

    // Saturating count of cycles spent in card busy during the operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busyCycles <= 32'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_busyCycles <= 32'd0;
        end else if ((r_state == ST_CARD_BUSY) && (r_busyCycles != 32'hFFFF_FFFF)) begin
            r_busyCycles <= r_busyCycles + 32'd1;
        end
    end

    assign busyCycles = r_busyCycles;
`endif

    assign bufAddr    = r_addr;
    assign bufRd      = w_rd;
    assign txValid    = w_stream;
    assign txLast     = w_stream && w_lastByte;
    assign txData     = w_stream ? w_qHead : 8'h00;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign aborted    = r_aborted;
    assign timeout    = r_timeout;
    assign blocksDone = r_blocksDone;

endmodule
`default_nettype wire

// File: tb/tb_sdc_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdc_write_sequencer
//  Description : Directed self-checking bench for sdc_write_sequencer
//                (512-byte blocks, 12-bit buffer address, 1000-cycle timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdc_write_sequencer;

    localparam int BB  = 512;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] startAddr = 12'h000;
    logic [15:0] blockCount = 16'd0;
    logic        abort = 1'b0;
    logic [11:0] bufAddr;
    logic        bufRd;
    logic [7:0]  bufData = 8'h00;
    logic [7:0]  txData;
    logic        txValid;
    logic        txLast;
    logic        txReady = 1'b0;
    logic        txWaiting = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        timeout;
    logic [15:0] blocksDone;
`ifdef SDC_WRSEQ_STATS_EN
    logic [31:0] busyCycles;
`endif

    int total = 0;
    int bad   = 0;
    int reads = 0;
    int lasts = 0;

    sdc_write_sequencer #(
        .ADDR_W       (12),
        .BLOCK_BYTES  (BB),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .startAddr  (startAddr),
        .blockCount (blockCount),
        .abort      (abort),
        .bufAddr    (bufAddr),
        .bufRd      (bufRd),
        .bufData    (bufData),
        .txData     (txData),
        .txValid    (txValid),
        .txLast     (txLast),
        .txReady    (txReady),
        .txWaiting  (txWaiting),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .timeout    (timeout),
        .blocksDone (blocksDone)
`ifdef SDC_WRSEQ_STATS_EN
        ,
        .busyCycles (busyCycles)
`endif
    );

    always #5 clk = ~clk;

    // Sector buffer contents are a fixed function of the address
    function automatic logic [7:0] f(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    // Synchronous buffer RAM model, one-cycle read latency
    always @(posedge clk) begin
        if (bufRd) bufData <= f(bufAddr);
    end

    // Activity monitors: buffer reads and accepted block-final bytes
    always @(posedge clk) begin
        if (bufRd) reads <= reads + 1;
        if (txValid && txReady && txLast) lasts <= lasts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [11:0] a, input logic [15:0] n);
        startAddr  = a;
        blockCount = n;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Transmitter model: one ready pulse every 'gap' cycles, checking every byte of one block
    task automatic send_block(input string tag, input logic [11:0] base, input int gap,
                              input int abort_at, input int start_at);
        int w    = 0;
        int dErr = 0;
        int lErr = 0;
        int vErr = 0;
        while (!txValid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid_start"}, {31'd0, txValid}, 32'd1);
        for (int i = 0; i < BB; i++) begin
            logic [11:0] a;
            a = base + 12'(i);
            for (int g = 0; g < gap - 1; g++) begin
                if (i == abort_at && g == 0) abort = 1'b1;
                if (i == start_at && g == 0) begin
                    start      = 1'b1;
                    startAddr  = 12'h123;
                    blockCount = 16'd5;
                end
                if (txValid !== 1'b1) vErr++;
                if (txLast !== (i == BB - 1)) lErr++;
                @(negedge clk);
                start = 1'b0;
            end
            if (txValid !== 1'b1) vErr++;
            if (txData !== f(a)) dErr++;
            if (txLast !== (i == BB - 1)) lErr++;
            txReady = 1'b1;
            @(negedge clk);
            txReady = 1'b0;
        end
        chk({tag, "_data_errs"}, dErr, 0);
        chk({tag, "_last_errs"}, lErr, 0);
        chk({tag, "_valid_gaps"}, vErr, 0);
        chk({tag, "_valid_drop"}, {31'd0, txValid}, 32'd0);
    endtask

    // Card-busy pulse of 'len' cycles; returns one cycle after release is sampled
    task automatic card_busy(input int len);
        txWaiting = 1'b1;
        repeat (len) @(negedge clk);
        txWaiting = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int l0;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_txValid", {31'd0, txValid}, 32'd0);
        chk("rst_bufRd", {31'd0, bufRd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_blocksDone", {16'd0, blocksDone}, 32'd0);
        chk("rst_flags", {30'd0, aborted, timeout}, 32'd0);

        // Single block from address 0, ready every 2 cycles, 50-cycle card busy
        r0 = reads;
        do_start(12'h000, 16'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_block("t1", 12'h000, 2, -1, -1);
        card_busy(50);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_blocksDone", {16'd0, blocksDone}, 32'd1);
        chk("t1_flags", {30'd0, aborted, timeout}, 32'd0);
        chk("t1_reads", reads - r0, 512);
`ifdef SDC_WRSEQ_STATS_EN
        chk("t1_busyCycles", busyCycles, 32'd50);
`endif
        @(negedge clk);
        chk("t1_idle", {30'd0, busy, done}, 32'd0);

        // Three blocks from 0xE00 with address wrap, ready every 8 cycles
        r0 = reads;
        l0 = lasts;
        do_start(12'hE00, 16'd3);
        send_block("t2b1", 12'hE00, 8, -1, -1);
        card_busy(10);
        chk("t2_mid_done", {31'd0, done}, 32'd0);
        chk("t2_mid_blocks", {16'd0, blocksDone}, 32'd1);
        send_block("t2b2", 12'h000, 8, -1, -1);
        card_busy(10);
        chk("t2_mid_blocks2", {16'd0, blocksDone}, 32'd2);
        send_block("t2b3", 12'h200, 8, -1, -1);
        card_busy(10);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_blocksDone", {16'd0, blocksDone}, 32'd3);
        chk("t2_aborted", {31'd0, aborted}, 32'd0);
        chk("t2_reads", reads - r0, 1536);
        chk("t2_lasts", lasts - l0, 3);
        @(negedge clk);

        // Four blocks requested, abort raised at byte 100 of block 2
        r0 = reads;
        do_start(12'h100, 16'd4);
        send_block("t3b1", 12'h100, 2, -1, -1);
        card_busy(5);
        chk("t3_mid_blocks", {16'd0, blocksDone}, 32'd1);
        send_block("t3b2", 12'h300, 2, 100, -1);
        card_busy(5);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_blocksDone", {16'd0, blocksDone}, 32'd2);
        chk("t3_aborted", {31'd0, aborted}, 32'd1);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("t3_reads", reads - r0, 1024);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // Busy timeout: txWaiting never released
        do_start(12'h400, 16'd2);
        send_block("t4", 12'h400, 2, -1, -1);
        txWaiting = 1'b1;
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t4_latency", k, 1000);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_timeout", {31'd0, timeout}, 32'd1);
        chk("t4_blocksDone", {16'd0, blocksDone}, 32'd0);
        chk("t4_aborted", {31'd0, aborted}, 32'd0);
        txWaiting = 1'b0;
        @(negedge clk);

        // Zero-block operation completes immediately with no traffic
        r0 = reads;
        do_start(12'h700, 16'd0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_txValid", {31'd0, txValid}, 32'd0);
        chk("t5_timeout_clr", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        chk("t5_idle", {30'd0, busy, done}, 32'd0);
        chk("t5_reads", reads - r0, 0);

        // Start pulse during STREAM is ignored
        do_start(12'h600, 16'd1);
        send_block("t5s", 12'h600, 2, -1, 10);
        card_busy(5);
        chk("t5s_done", {31'd0, done}, 32'd1);
        chk("t5s_blocksDone", {16'd0, blocksDone}, 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-STREAM, then a clean block
        do_start(12'h800, 16'd1);
        k = 0;
        while (!txValid && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("t6_streaming", {31'd0, txValid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {30'd0, txValid, txLast}, 32'd0);
        chk("t6_rst_busy", {30'd0, busy, bufRd}, 32'd0);
        chk("t6_rst_addr", {20'd0, bufAddr}, 32'd0);
        chk("t6_rst_data", {24'd0, txData}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0 = reads;
        do_start(12'hA00, 16'd1);
        send_block("t6", 12'hA00, 2, -1, -1);
        card_busy(3);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_blocksDone", {16'd0, blocksDone}, 32'd1);
        chk("t6_reads", reads - r0, 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
